// File: rtl/pkg_cpu.sv
// Core-wide CPU constants shared with the memory arbiter.
package pkg_cpu;

  localparam logic cpu_data_acc_sz_8  = 1'b0;
  localparam logic cpu_data_acc_sz_16 = 1'b1;

endpackage

// File: rtl/spcpu_mem_arbiter_pkg.sv
// Types and helpers for the spcpu memory-port arbiter.
package pkg_mem_arb;

  localparam int unsigned ARB_ADDR_W = 16;
  localparam int unsigned ARB_DATA_W = 16;

  localparam logic SZ_8  = pkg_cpu::cpu_data_acc_sz_8;
  localparam logic SZ_16 = pkg_cpu::cpu_data_acc_sz_16;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_LS   = 2'd1,
    ARB_IF   = 2'd2,
    ARB_DBG  = 2'd3
  } arb_id_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic                  we;
    logic                  sz;
  } arb_req_t;

  // Halfword accesses must be even-aligned; byte accesses never fault.
  function automatic logic is_misaligned(input logic sz, input logic addr_lsb);
    return (sz == SZ_16) && addr_lsb;
  endfunction

  // Ack/err vector layout is {dbg, if, ls}.
  function automatic logic [2:0] id_onehot(input arb_id_t id);
    logic [2:0] v;
    v = 3'b000;
    case (id)
      ARB_LS:  v = 3'b001;
      ARB_IF:  v = 3'b010;
      ARB_DBG: v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/spcpu_mem_arbiter_prio_sel.sv
// Combinational grant picker: ls > if > dbg, unless dbg has been starved long enough.
module mem_arb_prio_sel
  import pkg_mem_arb::*;
(
  input  logic    i_elig_ls,
  input  logic    i_elig_if,
  input  logic    i_elig_dbg,
  input  logic    i_dbg_boost,
  output arb_id_t o_sel
);

  always_comb begin
    o_sel = ARB_NONE;
    if (i_dbg_boost && i_elig_dbg) begin
      o_sel = ARB_DBG;
    end else if (i_elig_ls) begin
      o_sel = ARB_LS;
    end else if (i_elig_if) begin
      o_sel = ARB_IF;
    end else if (i_elig_dbg) begin
      o_sel = ARB_DBG;
    end
  end

endmodule

// File: rtl/spcpu_mem_arbiter.sv
// Shares the single spcpu memory port between ls, if and dbg requesters, one access at a time.
// ADDR_W/DATA_W must match the widths of pkg_mem_arb::arb_req_t.
module spcpu_mem_arbiter
  import pkg_mem_arb::*;
#(
  parameter int unsigned ADDR_W     = ARB_ADDR_W,
  parameter int unsigned DATA_W     = ARB_DATA_W,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ls_req,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  input  logic              i_ls_we,
  input  logic              i_ls_sz,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic [DATA_W-1:0] i_if_wdata,
  input  logic              i_if_we,
  input  logic              i_if_sz,
  input  logic              i_dbg_req,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  input  logic              i_dbg_we,
  input  logic              i_dbg_sz,
  output logic              o_ls_ack,
  output logic              o_if_ack,
  output logic              o_dbg_ack,
  output logic              o_ls_err,
  output logic              o_if_err,
  output logic              o_dbg_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_sz,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output arb_id_t           o_owner
);

  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  arb_state_t        r_state,      w_state_nxt;
  arb_id_t           r_owner,      w_owner_nxt;
  logic [LAT_W-1:0]  r_lat_cnt,    w_lat_cnt_nxt;
  logic [STV_W-1:0]  r_starve_cnt, w_starve_cnt_nxt;
  arb_req_t          r_req,        w_req_nxt;
  logic              r_mem_en,     w_mem_en_nxt;
  logic [2:0]        r_ack,        w_ack_nxt;
  logic [2:0]        r_err,        w_err_nxt;
  logic [DATA_W-1:0] r_rdata,      w_rdata_nxt;

  logic     w_elig_ls, w_elig_if, w_elig_dbg;
  logic     w_boost, w_dbg_grant;
  arb_id_t  w_sel;
  arb_req_t w_sel_req;

  // A requester whose ack is high this cycle still shows req; mask it so it is not re-granted.
  assign w_elig_ls  = i_ls_req  & ~r_ack[0];
  assign w_elig_if  = i_if_req  & ~r_ack[1];
  assign w_elig_dbg = i_dbg_req & ~r_ack[2];
  assign w_boost    = (r_starve_cnt == STV_W'(STARVE_MAX));

  mem_arb_prio_sel u_prio_sel (
    .i_elig_ls   (w_elig_ls),
    .i_elig_if   (w_elig_if),
    .i_elig_dbg  (w_elig_dbg),
    .i_dbg_boost (w_boost),
    .o_sel       (w_sel)
  );

  assign w_dbg_grant = (r_state == IDLE) && (w_sel == ARB_DBG);

  always_comb begin
    w_sel_req = '0;
    unique case (w_sel)
      ARB_LS:  w_sel_req = '{addr: i_ls_addr,  wdata: i_ls_wdata,  we: i_ls_we,  sz: i_ls_sz};
      ARB_IF:  w_sel_req = '{addr: i_if_addr,  wdata: i_if_wdata,  we: i_if_we,  sz: i_if_sz};
      ARB_DBG: w_sel_req = '{addr: i_dbg_addr, wdata: i_dbg_wdata, we: i_dbg_we, sz: i_dbg_sz};
      default: w_sel_req = '0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_lat_cnt_nxt = r_lat_cnt;
    w_req_nxt     = r_req;
    w_mem_en_nxt  = r_mem_en;
    w_ack_nxt     = 3'b000;
    w_err_nxt     = 3'b000;
    w_rdata_nxt   = r_rdata;

    unique case (r_state)
      IDLE: begin
        w_owner_nxt = ARB_NONE;
        if (w_sel != ARB_NONE) begin
          w_req_nxt = w_sel_req;
          if (is_misaligned(w_sel_req.sz, w_sel_req.addr[0])) begin
            w_ack_nxt   = id_onehot(w_sel);
            w_err_nxt   = id_onehot(w_sel);
            w_rdata_nxt = '0;
          end else begin
            w_state_nxt   = BUSY;
            w_owner_nxt   = w_sel;
            w_lat_cnt_nxt = LAT_W'(MEM_LAT - 1);
            w_mem_en_nxt  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (r_lat_cnt != '0) begin
          w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
        end else begin
          if (r_req.we) begin
            w_rdata_nxt = '0;
          end else if (r_req.sz == SZ_16) begin
            w_rdata_nxt = i_mem_rdata;
          end else begin
            w_rdata_nxt = {{(DATA_W - 8){1'b0}}, i_mem_rdata[7:0]};
          end
          w_ack_nxt    = id_onehot(r_owner);
          w_mem_en_nxt = 1'b0;
          w_state_nxt  = IDLE;
          w_owner_nxt  = ARB_NONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (!i_dbg_req || w_dbg_grant) begin
      w_starve_cnt_nxt = '0;
    end else if (!w_boost) begin
      w_starve_cnt_nxt = r_starve_cnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= ARB_NONE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_req        <= '0;
      r_mem_en     <= 1'b0;
      r_ack        <= 3'b000;
      r_err        <= 3'b000;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_lat_cnt    <= w_lat_cnt_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_req        <= w_req_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_ack        <= w_ack_nxt;
      r_err        <= w_err_nxt;
      r_rdata      <= w_rdata_nxt;
    end
  end

  assign o_ls_ack    = r_ack[0];
  assign o_if_ack    = r_ack[1];
  assign o_dbg_ack   = r_ack[2];
  assign o_ls_err    = r_err[0];
  assign o_if_err    = r_err[1];
  assign o_dbg_err   = r_err[2];
  assign o_rdata     = r_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_addr  = r_req.addr;
  assign o_mem_wdata = r_req.wdata;
  assign o_mem_we    = r_mem_en & r_req.we;
  assign o_mem_sz    = r_req.sz;
  assign o_busy      = (r_state == BUSY);
  assign o_owner     = r_owner;

endmodule

// File: tb/tb_spcpu_mem_arbiter.sv
// Scoreboard bench for spcpu_mem_arbiter: agents push expected responses, a monitor pops and checks.
module tb_spcpu_mem_arbiter;
  import pkg_mem_arb::*;

  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam logic S16 = pkg_cpu::cpu_data_acc_sz_16;
  localparam logic S8  = pkg_cpu::cpu_data_acc_sz_8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        t_req[3];
  logic [15:0] t_addr[3];
  logic [15:0] t_wdata[3];
  logic        t_we[3];
  logic        t_sz[3];

  logic [2:0]  acks, errs;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, mem_sz, busy;
  arb_id_t     owner;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        sz;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t    exp_q[3][$];
  arb_id_t grant_log[$];
  int      n_checks = 0;
  int      n_errors = 0;
  bit      in_rst_test = 1'b0;

  spcpu_mem_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_ls_req    (t_req[0]),
    .i_ls_addr   (t_addr[0]),
    .i_ls_wdata  (t_wdata[0]),
    .i_ls_we     (t_we[0]),
    .i_ls_sz     (t_sz[0]),
    .i_if_req    (t_req[1]),
    .i_if_addr   (t_addr[1]),
    .i_if_wdata  (t_wdata[1]),
    .i_if_we     (t_we[1]),
    .i_if_sz     (t_sz[1]),
    .i_dbg_req   (t_req[2]),
    .i_dbg_addr  (t_addr[2]),
    .i_dbg_wdata (t_wdata[2]),
    .i_dbg_we    (t_we[2]),
    .i_dbg_sz    (t_sz[2]),
    .o_ls_ack    (acks[0]),
    .o_if_ack    (acks[1]),
    .o_dbg_ack   (acks[2]),
    .o_ls_err    (errs[0]),
    .o_if_err    (errs[1]),
    .o_dbg_err   (errs[2]),
    .o_rdata     (rdata),
    .o_mem_en    (mem_en),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .o_mem_sz    (mem_sz),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy),
    .o_owner     (owner)
  );

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    if (a == 16'h0021) return 16'h5566;
    return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C};
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  // Expected response straight from the access rules.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] wd,
                                 input logic we, input logic sz);
    exp_t e;
    logic [15:0] m;
    m       = mem_fn(a);
    e.addr  = a;
    e.wdata = wd;
    e.we    = we;
    e.sz    = sz;
    e.err   = (sz == S16) && a[0];
    if (e.err || we)    e.rdata = 16'h0000;
    else if (sz == S16) e.rdata = m;
    else                e.rdata = {8'h00, m[7:0]};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic do_req(input int id, input logic [15:0] a, input logic [15:0] wd,
                        input logic we, input logic sz, input int exp_lat, input int max_wait);
    int n;
    bit got;
    @(negedge clk);
    exp_q[id].push_back(model(a, wd, we, sz));
    t_addr[id]  = a;
    t_wdata[id] = wd;
    t_we[id]    = we;
    t_sz[id]    = sz;
    t_req[id]   = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (acks[id]) got = 1'b1;
    end
    t_req[id] = 1'b0;
    if (!got) begin
      chk($sformatf("ack_timeout_id%0d", id), 32'(got), 32'd1);
      exp_q[id].delete();
    end else begin
      if (exp_lat > 0) chk($sformatf("latency_id%0d", id), 32'(n), 32'(exp_lat));
      if (max_wait > 0 && n > max_wait) chk($sformatf("wait_bound_id%0d", id), 32'(n), 32'(max_wait));
    end
  endtask

  task automatic rand_agent(input int id, input int cnt);
    logic [15:0] a, wd;
    logic we, sz;
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a  = 16'($urandom);
      wd = 16'($urandom);
      we = 1'($urandom);
      sz = 1'($urandom);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      do_req(id, a, wd, we, sz, 0, 0);
    end
  endtask

  // Monitor: pops on every ack and checks mem-port behaviour at grant and at completion.
  initial begin : monitor
    bit   prev_en;
    int   run;
    exp_t e;
    int   oid;
    prev_en = 1'b0;
    run     = 0;
    forever begin
      @(negedge clk);
      if (reset || in_rst_test) begin
        prev_en = 1'b0;
        run     = 0;
      end else begin
        chk("one_ack_err_implies_ack",
            32'({($countones(acks) > 1), ((errs & ~acks) != 3'b000)}), 32'd0);
        for (int id = 0; id < 3; id++) begin
          if (acks[id]) begin
            if (exp_q[id].size() == 0) begin
              chk($sformatf("unexpected_ack_id%0d", id), 32'(acks[id]), 32'd0);
            end else begin
              e = exp_q[id].pop_front();
              chk($sformatf("err_id%0d", id), 32'(errs[id]), 32'(e.err));
              chk($sformatf("rdata_id%0d", id), 32'(rdata), 32'(e.rdata));
            end
          end
        end
        if (mem_en && !prev_en) begin
          grant_log.push_back(owner);
          oid = int'(owner) - 1;
          if (owner == ARB_NONE || exp_q[oid].size() == 0) begin
            chk("grant_owner_valid", 32'(owner), 32'hFFFF);
          end else begin
            e = exp_q[oid][0];
            chk("grant_not_misaligned", 32'(e.err), 32'd0);
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_sz", 32'(mem_sz), 32'(e.sz));
          end
        end
        if (mem_en) run++;
        if (!mem_en && prev_en) begin
          chk("mem_en_cycles", 32'(run), 32'(MEM_LAT));
          chk("ack_after_access", 32'(acks != 3'b000), 32'd1);
          run = 0;
        end
        prev_en = mem_en;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int          n;
    logic [2:0]  seen;
    arb_id_t     exp_order[6];
    for (int i = 0; i < 3; i++) begin
      t_req[i]   = 1'b0;
      t_addr[i]  = '0;
      t_wdata[i] = '0;
      t_we[i]    = 1'b0;
      t_sz[i]    = S16;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_flags", 32'({acks, errs, mem_en, mem_we, mem_sz, busy}), 32'd0);
    chk("rst_data", {rdata, mem_addr}, 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_owner", 32'(owner), 32'(ARB_NONE));

    // Plain halfword read; ack lands MEM_LAT+1 cycles after the request is sampled.
    do_req(0, 16'h0010, 16'h0000, 1'b0, S16, MEM_LAT + 1, 0);

    // ls and if together: ls first, then if exactly once.
    grant_log.delete();
    fork
      do_req(0, 16'h0200, 16'h1111, 1'b0, S16, 0, 0);
      do_req(1, 16'h0300, 16'h2222, 1'b0, S16, 0, 0);
    join
    chk("prio_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("prio_first_ls", 32'(grant_log[0]), 32'(ARB_LS));
      chk("prio_then_if", 32'(grant_log[1]), 32'(ARB_IF));
    end

    // Misaligned halfword fetch: no memory access, ack+err next cycle.
    do_req(1, 16'h0003, 16'h0000, 1'b0, S16, 1, 0);

    // Byte write, then byte read of the same address.
    do_req(2, 16'h0021, 16'h12AB, 1'b1, S8, MEM_LAT + 1, 0);
    do_req(2, 16'h0021, 16'h0000, 1'b0, S8, MEM_LAT + 1, 0);

    // dbg against continuous ls/if traffic: it must break in after STARVE_MAX waiting cycles.
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 5; k++) do_req(0, 16'(16'h0400 + 2 * k), 16'h0, 1'b0, S16, 0, 0);
      end
      begin
        for (int k = 0; k < 5; k++) do_req(1, 16'(16'h0500 + 2 * k), 16'h0, 1'b0, S16, 0, 0);
      end
      begin
        do_req(2, 16'h0600, 16'h0, 1'b0, S16, 0, 10);
        do_req(2, 16'h0602, 16'h0, 1'b0, S16, 0, 10);
      end
    join
    exp_order = '{ARB_LS, ARB_IF, ARB_DBG, ARB_LS, ARB_IF, ARB_DBG};
    chk("starve_grant_count_ge6", 32'(grant_log.size() >= 6), 32'd1);
    if (grant_log.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("starve_order_%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));
      end
    end

    // Randomized mixed traffic from all three requesters.
    fork
      rand_agent(0, 25);
      rand_agent(1, 25);
      rand_agent(2, 25);
    join

    // Reset during the first BUSY cycle aborts the access with no ack.
    in_rst_test = 1'b1;
    @(negedge clk);
    t_addr[0] = 16'h0040;
    t_we[0]   = 1'b0;
    t_sz[0]   = S16;
    t_req[0]  = 1'b1;
    n = 0;
    while (!mem_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_busy", 32'({mem_en, busy}), 32'd3);
    reset    = 1'b1;
    t_req[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_owner", 32'(owner), 32'(ARB_NONE));
    reset = 1'b0;
    seen  = acks;
    repeat (8) begin
      @(negedge clk);
      seen = seen | acks;
    end
    chk("rst_mid_no_ack", 32'(seen), 32'd0);
    in_rst_test = 1'b0;

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
